// File: rtl/decode_stage.sv
// RV32 instruction-decode stage: combinational decode of the incoming word, captured
// into a two-entry (main + skid) output buffer with valid/ready handshake and flush.
module decode_stage #(
  parameter int XLEN         = 32,
  parameter bit SUPPRESS_RD0 = 1'b1,
  parameter bit EN_SYSTEM    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [14:0]     out_ctrl,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  output logic            out_fence,
  output logic            out_system
);

  typedef struct packed {
    logic [14:0]     ctrl;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] pc;
    logic            illegal;
    logic            fence;
    logic            system;
  } entry_t;

  entry_t      dec_s;
  entry_t      main_r;
  entry_t      skid_r;
  logic        main_valid_r;
  logic        skid_valid_r;
  logic [14:0] ctrl_s;
  logic [31:0] imm32_s;
  logic        illegal_s;
  logic        fence_s;
  logic        system_s;
  logic        accept_s;
  logic        drain_s;

  // Opcode to control bundle, immediate formatting and entry assembly.
  always_comb begin
    ctrl_s    = 15'b0;
    illegal_s = 1'b0;
    fence_s   = 1'b0;
    system_s  = 1'b0;
    imm32_s   = 32'b0;
    case (in_instr[6:0])
      7'b0000011: ctrl_s = 15'b1_000_0_0_1_1_0_01_0_0_00;
      7'b0010011: ctrl_s = 15'b1_000_0_0_1_0_0_00_0_0_10;
      7'b0010111: ctrl_s = 15'b1_100_0_1_1_0_0_00_0_0_00;
      7'b0100011: ctrl_s = 15'b0_001_0_0_1_1_1_00_0_0_00;
      7'b0110011: ctrl_s = 15'b1_000_0_0_0_0_0_00_0_0_10;
      7'b0110111: ctrl_s = 15'b1_100_0_0_0_0_0_11_0_0_00;
      7'b1100011: ctrl_s = 15'b0_010_0_0_0_0_0_00_1_0_01;
      7'b1100111: ctrl_s = 15'b1_000_1_0_1_0_0_10_0_1_00;
      7'b1101111: ctrl_s = 15'b1_011_0_0_0_0_0_10_0_1_00;
      7'b0001111: begin
        if (EN_SYSTEM) fence_s = 1'b1;
        else           illegal_s = 1'b1;
      end
      7'b1110011: begin
        if (EN_SYSTEM) system_s = 1'b1;
        else           illegal_s = 1'b1;
      end
      default: illegal_s = 1'b1;
    endcase
    ctrl_s[14] = ctrl_s[14] & ~(SUPPRESS_RD0 & (in_instr[11:7] == 5'd0));
    case (ctrl_s[13:11])
      3'b000:  imm32_s = {{20{in_instr[31]}}, in_instr[31:20]};
      3'b001:  imm32_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'b010:  imm32_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      3'b011:  imm32_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      3'b100:  imm32_s = {in_instr[31:12], 12'b0};
      default: imm32_s = 32'b0;
    endcase
    dec_s.ctrl     = ctrl_s;
    dec_s.imm      = XLEN'($signed(imm32_s));
    dec_s.rs1      = in_instr[19:15];
    dec_s.rs2      = in_instr[24:20];
    dec_s.rd       = in_instr[11:7];
    dec_s.funct3   = in_instr[14:12];
    dec_s.funct7b5 = in_instr[30];
    dec_s.pc       = in_pc;
    dec_s.illegal  = illegal_s;
    dec_s.fence    = fence_s;
    dec_s.system   = system_s;
  end

  assign in_ready = ~skid_valid_r;
  assign accept_s = in_valid & ~skid_valid_r;
  assign drain_s  = main_valid_r & out_ready;

  // Main/skid buffer: skid refills main on drain, new entries go to skid while main is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (!main_valid_r || drain_s) begin
      if (skid_valid_r) begin
        main_r       <= skid_r;
        main_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        main_r       <= dec_s;
        main_valid_r <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
    end
  end

  assign out_valid    = main_valid_r;
  assign out_ctrl     = main_r.ctrl;
  assign out_imm      = main_r.imm;
  assign out_rs1      = main_r.rs1;
  assign out_rs2      = main_r.rs2;
  assign out_rd       = main_r.rd;
  assign out_funct3   = main_r.funct3;
  assign out_funct7b5 = main_r.funct7b5;
  assign out_pc       = main_r.pc;
  assign out_illegal  = main_r.illegal;
  assign out_fence    = main_r.fence;
  assign out_system   = main_r.system;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a default instance (XLEN=32) and a variant
// (XLEN=64, EN_SYSTEM=0, SUPPRESS_RD0=0) share the same stimulus.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic [63:0] in_pc64;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_funct7b5, out_illegal, out_fence, out_system;
  logic [14:0] out_ctrl;
  logic [31:0] out_imm, out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;

  logic        w_in_ready, w_out_valid, w_out_funct7b5, w_out_illegal, w_out_fence, w_out_system;
  logic [14:0] w_out_ctrl;
  logic [63:0] w_out_imm, w_out_pc;
  logic [4:0]  w_out_rs1, w_out_rs2, w_out_rd;
  logic [2:0]  w_out_funct3;

  int total = 0;
  int bad = 0;

  assign in_pc64 = {32'h0, in_pc};

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_pc(out_pc),
    .out_illegal(out_illegal), .out_fence(out_fence), .out_system(out_system)
  );

  decode_stage #(.XLEN(64), .SUPPRESS_RD0(1'b0), .EN_SYSTEM(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_ctrl(w_out_ctrl), .out_imm(w_out_imm), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2),
    .out_rd(w_out_rd), .out_funct3(w_out_funct3), .out_funct7b5(w_out_funct7b5),
    .out_pc(w_out_pc), .out_illegal(w_out_illegal), .out_fence(w_out_fence),
    .out_system(w_out_system)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    total++; if (out_ctrl !== 15'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", out_ctrl); end
    total++; if (out_imm !== 32'h0 || out_pc !== 32'h0) begin bad++; $display("FAIL reset_payload imm=%h pc=%h want=0", out_imm, out_pc); end
    total++; if (w_out_imm !== 64'h0 || w_out_illegal !== 1'b0) begin bad++; $display("FAIL reset_payload64 imm=%h ill=%b want=0", w_out_imm, w_out_illegal); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    in_pc = 32'h0000_0100;
    in_instr = 32'h0050_0093;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b want=1", out_valid); end
    total++; if (out_ctrl !== 15'b1_000_0_0_1_0_0_00_0_0_10) begin bad++; $display("FAIL addi_ctrl got=%b want=100000100000010", out_ctrl); end
    total++; if (out_imm !== 32'h5) begin bad++; $display("FAIL addi_imm got=%h want=5", out_imm); end
    total++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0) begin bad++; $display("FAIL addi_regs rd=%0d rs1=%0d want=1,0", out_rd, out_rs1); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL addi_illegal got=%b want=0", out_illegal); end
    total++; if (out_pc !== 32'h100) begin bad++; $display("FAIL addi_pc got=%h want=100", out_pc); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b want=0", out_valid); end
  endtask

  // Back-to-back stream with out_ready high: each cycle both accepts and drains.
  task automatic test_imm_formats();
    logic [31:0] ins [5];
    logic [14:0] ctl [5];
    logic [63:0] imm [5];
    ins[0] = 32'hFE00_0EE3; ctl[0] = 15'b0_010_0_0_0_0_0_00_1_0_01; imm[0] = 64'hFFFF_FFFF_FFFF_FFFC;
    ins[1] = 32'h0080_00EF; ctl[1] = 15'b1_011_0_0_0_0_0_10_0_1_00; imm[1] = 64'h0000_0000_0000_0008;
    ins[2] = 32'hFE11_2E23; ctl[2] = 15'b0_001_0_0_1_1_1_00_0_0_00; imm[2] = 64'hFFFF_FFFF_FFFF_FFFC;
    ins[3] = 32'h8000_0537; ctl[3] = 15'b1_100_0_0_0_0_0_11_0_0_00; imm[3] = 64'hFFFF_FFFF_8000_0000;
    ins[4] = 32'hFFF0_0083; ctl[4] = 15'b1_000_0_0_1_1_0_01_0_0_00; imm[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_instr = ins[i];
      in_pc = 32'h200 + 32'(i * 4);
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fmt%0d_valid got=%b want=1", i, out_valid); end
      total++; if (out_ctrl !== ctl[i]) begin bad++; $display("FAIL fmt%0d_ctrl got=%b want=%b", i, out_ctrl, ctl[i]); end
      total++; if (out_imm !== imm[i][31:0]) begin bad++; $display("FAIL fmt%0d_imm got=%h want=%h", i, out_imm, imm[i][31:0]); end
      total++; if (w_out_imm !== imm[i]) begin bad++; $display("FAIL fmt%0d_imm64 got=%h want=%h", i, w_out_imm, imm[i]); end
      total++; if (out_pc !== 32'h200 + 32'(i * 4)) begin bad++; $display("FAIL fmt%0d_pc got=%h", i, out_pc); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal_system();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0000_0000;
    step();
    total++; if (out_illegal !== 1'b1 || out_ctrl !== 15'h0) begin bad++; $display("FAIL ill_zero ill=%b ctrl=%h want=1,0", out_illegal, out_ctrl); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ill_zero_valid got=%b want=1", out_valid); end
    in_instr = 32'h0000_0073;
    step();
    total++; if (out_system !== 1'b1 || out_illegal !== 1'b0 || out_ctrl !== 15'h0) begin bad++; $display("FAIL sys_en sys=%b ill=%b ctrl=%h want=1,0,0", out_system, out_illegal, out_ctrl); end
    total++; if (w_out_illegal !== 1'b1 || w_out_system !== 1'b0 || w_out_ctrl !== 15'h0) begin bad++; $display("FAIL sys_dis ill=%b sys=%b ctrl=%h want=1,0,0", w_out_illegal, w_out_system, w_out_ctrl); end
    in_instr = 32'h0000_000F;
    step();
    total++; if (out_fence !== 1'b1 || out_illegal !== 1'b0) begin bad++; $display("FAIL fence_en fence=%b ill=%b want=1,0", out_fence, out_illegal); end
    total++; if (w_out_illegal !== 1'b1 || w_out_fence !== 1'b0) begin bad++; $display("FAIL fence_dis ill=%b fence=%b want=1,0", w_out_illegal, w_out_fence); end
    in_instr = 32'h0000_00EE;
    step();
    total++; if (out_illegal !== 1'b1 || out_ctrl[3:2] !== 2'b00) begin bad++; $display("FAIL ill_lowbits ill=%b ctrl=%h want=1,0", out_illegal, out_ctrl); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_suppress_rd0();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0000_0033;
    step();
    in_valid = 1'b0;
    total++; if (out_ctrl !== 15'b0_000_0_0_0_0_0_00_0_0_10) begin bad++; $display("FAIL rd0_suppr got=%b want=000000000000010", out_ctrl); end
    total++; if (w_out_ctrl !== 15'b1_000_0_0_0_0_0_00_0_0_10) begin bad++; $display("FAIL rd0_keep got=%b want=100000000000010", w_out_ctrl); end
    step();
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h0050_0093;
    step();
    total++; if (in_ready !== 1'b1 || out_rd !== 5'd1) begin bad++; $display("FAIL skid_first ready=%b rd=%0d want=1,1", in_ready, out_rd); end
    in_instr = 32'h0050_0113;
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_full ready=%b want=0", in_ready); end
    in_instr = 32'h0050_0193;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_imm !== 32'h5) begin bad++; $display("FAIL skid_hold valid=%b rd=%0d imm=%h want=1,1,5", out_valid, out_rd, out_imm); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_rd !== 5'd2 || in_ready !== 1'b1) begin bad++; $display("FAIL skid_second valid=%b rd=%0d ready=%b want=1,2,1", out_valid, out_rd, in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL skid_empty valid=%b rd=%0d want=0", out_valid, out_rd); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h0050_0093;
    step();
    in_instr = 32'h0050_0113;
    step();
    flush = 1'b1;
    in_instr = 32'h0050_0193;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_state valid=%b ready=%b want=0,1", out_valid, in_ready); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop valid=%b rd=%0d want=0", out_valid, out_rd); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h0050_0093;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre valid=%b want=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 15'h0) begin bad++; $display("FAIL rst_async valid=%b ready=%b ctrl=%h want=0,1,0", out_valid, in_ready, out_ctrl); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_after valid=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_imm_formats();
    test_illegal_system();
    test_suppress_rd0();
    test_skid();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
